// File: rtl/lfsr_step_ctrl.sv
// State holder and step controller for an 8-bit LFSR: synchronizes and debounces a step
// button, captures the external next-value stage on each accepted press, supports seed load.
module lfsr_step_ctrl #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter logic [7:0]  SEED       = 8'h01,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn,
  input  logic             load,
  input  logic [7:0]       seed_in,
  input  logic [7:0]       shift_rs,
  output logic [7:0]       shift_src,
  output logic [7:0]       state_out,
  output logic             step_pulse,
  output logic [CNT_W-1:0] step_cnt
);

  localparam int unsigned DCW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);

  logic           sync1;
  logic           btn_sync;
  logic           deb;
  logic           deb_q;
  logic [DCW-1:0] deb_cnt;

  // Two-flop synchronizer, no logic between the stages
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sync1    <= btn;
      btn_sync <= sync1;
    end
  end

  // Debounce: level flips only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else if (btn_sync != deb) begin
      if (deb_cnt == DEB_LAST) begin
        deb     <= btn_sync;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DCW'(1);
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  // One-cycle strobe on the debounced rising edge only
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_q      <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      deb_q      <= deb;
      step_pulse <= deb & ~deb_q;
    end
  end

  // Load outranks a step; an all-zero value is replaced by SEED to avoid lock-up
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_out <= SEED;
      step_cnt  <= '0;
    end else if (load) begin
      state_out <= (seed_in == 8'h00) ? SEED : seed_in;
      step_cnt  <= '0;
    end else if (step_pulse) begin
      state_out <= (shift_rs == 8'h00) ? SEED : shift_rs;
      step_cnt  <= step_cnt + CNT_W'(1);
    end
  end

  assign shift_src = state_out;

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// Randomized scoreboard bench for lfsr_step_ctrl with a behavioural press model and an
// 8-bit maximal-length next-value stage standing in for the shift block.
module tb_lfsr_step_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned CW   = 8;
  localparam logic [7:0]  SEED = 8'h01;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn = 1'b0;
  logic          load = 1'b0;
  logic [7:0]    seed_in = 8'h00;
  logic [7:0]    shift_rs;
  logic [7:0]    shift_src;
  logic [7:0]    state_out;
  logic          step_pulse;
  logic [CW-1:0] step_cnt;
  logic          force_zero = 1'b0;

  always #5 clk = ~clk;

  // x^8+x^6+x^5+x^4+1, right-shifting Fibonacci form (0x01 -> 0x80 -> 0x40 ...)
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
  endfunction

  assign shift_rs = force_zero ? 8'h00 : lfsr_next(shift_src);

  lfsr_step_ctrl #(.DEB_CYCLES(DEB), .SEED(SEED), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .load(load), .seed_in(seed_in),
    .shift_rs(shift_rs), .shift_src(shift_src), .state_out(state_out),
    .step_pulse(step_pulse), .step_cnt(step_cnt)
  );

  typedef struct packed {
    logic [7:0]    st;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend;
  bit   chk = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  // Behavioural model: committed state plus press run-length tracking
  logic [7:0]    m_state;
  logic [CW-1:0] m_cnt;
  logic          m_deb;
  logic          m_last;
  int            m_run;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every step_pulse consumes one expected result, checked after the update edge
  always @(negedge clk) begin
    if (chk) begin
      check("step_state", int'(state_out), int'(pend.st));
      check("step_cnt", int'(step_cnt), int'(pend.cnt));
      check("state_nonzero", int'(state_out != 8'h00), 1);
      chk = 1'b0;
    end
    check("shift_src", int'(shift_src), int'(state_out));
    if (rst_n && step_pulse) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", int'(step_pulse), 0);
      end else begin
        pend = exp_q.pop_front();
        chk  = 1'b1;
      end
    end
  end

  task automatic model_reset();
    m_state = SEED;
    m_cnt   = '0;
    m_deb   = 1'b0;
    m_last  = 1'b0;
    m_run   = 0;
  endtask

  task automatic push_step();
    logic [7:0] n;
    n = force_zero ? 8'h00 : lfsr_next(m_state);
    m_state = (n == 8'h00) ? SEED : n;
    m_cnt   = m_cnt + CW'(1);
    exp_q.push_back('{st: m_state, cnt: m_cnt});
  endtask

  // Hold btn at v for len cycles; a run of DEB equal samples flips the debounced level
  task automatic drive_seg(input logic v, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      btn = v;
      if (v == m_last) m_run++;
      else begin
        m_last = v;
        m_run  = 1;
      end
      if (v != m_deb && m_run >= int'(DEB)) begin
        m_deb = v;
        if (v) push_step();
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !chk) break;
      @(negedge clk);
    end
    check("drain", exp_q.size() + int'(chk), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    btn   = 1'b0;
    load  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", int'(state_out), int'(SEED));
    check("rst_cnt", int'(step_cnt), 0);
    check("rst_pulse", int'(step_pulse), 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic do_load(input logic [7:0] s);
    @(negedge clk);
    load    = 1'b1;
    seed_in = s;
    @(negedge clk);
    load    = 1'b0;
    m_state = (s == 8'h00) ? SEED : s;
    m_cnt   = '0;
    check("load_state", int'(state_out), int'(m_state));
    check("load_cnt", int'(step_cnt), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int edges;
    bit found;

    // Reset, then idle
    model_reset();
    do_reset();
    drive_seg(1'b0, 50);
    check("idle_state", int'(state_out), 8'h01);
    check("idle_cnt", int'(step_cnt), 0);

    // First press with latency measurement
    push_step();
    @(negedge clk);
    btn   = 1'b1;
    seen  = -1;
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (step_pulse && seen < 0) seen = edges;
    end
    m_deb = 1'b1; m_last = 1'b1; m_run = 21;
    check("press_latency", seen, 7);
    drive_seg(1'b0, 12);
    wait_drain();
    check("press1_state", int'(state_out), 8'h80);
    check("press1_cnt", int'(step_cnt), 1);
    drive_seg(1'b1, 10);
    drive_seg(1'b0, 12);
    wait_drain();
    check("press2_state", int'(state_out), 8'h40);
    check("press2_cnt", int'(step_cnt), 2);

    // Glitch and bounce
    drive_seg(1'b1, 3);
    drive_seg(1'b0, 12);
    wait_drain();
    check("glitch_state", int'(state_out), 8'h40);
    drive_seg(1'b1, 1); drive_seg(1'b0, 1); drive_seg(1'b1, 1); drive_seg(1'b0, 1);
    drive_seg(1'b1, 10);
    drive_seg(1'b0, 12);
    wait_drain();
    check("bounce_state", int'(state_out), 8'h20);
    check("bounce_cnt", int'(step_cnt), 3);

    // Loads, including a zero seed
    do_load(8'h5A);
    do_load(8'h00);
    check("zero_seed", int'(state_out), 8'h01);

    // Load in the same cycle as step_pulse wins
    exp_q.push_back('{st: 8'h33, cnt: CW'(0)});
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      btn = 1'b1;
      if (step_pulse) begin
        found   = 1'b1;
        load    = 1'b1;
        seed_in = 8'h33;
      end
    end
    check("lw_pulse_seen", int'(found), 1);
    @(negedge clk);
    load = 1'b0;
    m_state = 8'h33; m_cnt = '0; m_deb = 1'b1; m_last = 1'b1; m_run = 8;
    drive_seg(1'b0, 12);
    wait_drain();
    check("lw_state", int'(state_out), 8'h33);
    check("lw_cnt", int'(step_cnt), 0);

    // Lock-up guard: zero next value is replaced by SEED
    force_zero = 1'b1;
    drive_seg(1'b1, 8);
    drive_seg(1'b0, 12);
    wait_drain();
    force_zero = 1'b0;
    check("lockup_state", int'(state_out), 8'h01);
    check("lockup_cnt", int'(step_cnt), 1);

    // Randomized press/bounce traffic with occasional seed loads
    for (int r = 0; r < 6; r++) begin
      do_load(8'($urandom_range(0, 255)));
      for (int i = 0; i < 25; i++)
        drive_seg(1'($urandom_range(0, 1)), $urandom_range(1, 8));
      drive_seg(1'b0, 14);
      wait_drain();
    end

    // Full period from SEED, then counter wrap
    do_reset();
    for (int i = 0; i < 255; i++) begin
      drive_seg(1'b1, 6);
      drive_seg(1'b0, 6);
    end
    drive_seg(1'b0, 8);
    wait_drain();
    check("period_state", int'(state_out), 8'h01);
    check("period_cnt", int'(step_cnt), 255);
    drive_seg(1'b1, 6);
    drive_seg(1'b0, 12);
    wait_drain();
    check("wrap_cnt", int'(step_cnt), 0);
    check("wrap_state", int'(state_out), 8'h80);

    // Reset while the debounce counter is at 2 discards the press
    @(negedge clk);
    btn = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    btn   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive_seg(1'b0, 30);
    check("rstmid_state", int'(state_out), 8'h01);
    check("rstmid_cnt", int'(step_cnt), 0);
    check("rstmid_pulse", int'(step_pulse), 0);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
